// File: rtl/button_press_decoder.sv
// button_press_decoder: classifies a debounced button level into short, long and double press pulses.
module button_press_decoder #(
  parameter int LONG_TICKS = 25000000,
  parameter int GAP_TICKS  = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  input  logic enable,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND_HELD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic btn_prev_q, short_q, short_d, long_q, long_d, double_q, double_d;
  logic rise, fall;
  assign rise = btn_level & ~btn_prev_q;
  assign fall = ~btn_level & btn_prev_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    short_d = 1'b0;
    long_d = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = PRESSED;
        cnt_d = CNT_W'(1);
      end
      PRESSED: if (btn_level) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(LONG_TICKS)) begin
          long_d = 1'b1;
          state_d = LONG_HELD;
        end
      end else begin
        state_d = GAP;
        cnt_d = CNT_W'(1);
      end
      LONG_HELD, SECOND_HELD: if (fall) state_d = IDLE;
      GAP: if (rise) begin
        double_d = cnt_q < CNT_W'(GAP_TICKS);
        state_d = double_d ? SECOND_HELD : IDLE;
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(GAP_TICKS)) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a disabled decoder drops whatever gesture was in flight
    if (!enable) begin
      state_d = IDLE;
      cnt_d = '0;
      short_d = 1'b0;
      long_d = 1'b0;
      double_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      btn_prev_q <= 1'b1;
      short_q <= 1'b0;
      long_q <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      btn_prev_q <= btn_level;
      short_q <= short_d;
      long_q <= long_d;
      double_q <= double_d;
    end
  end
  assign short_press = short_q;
  assign long_press = long_q;
  assign double_press = double_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: directed gestures with a pulse scoreboard checked by an independent monitor.
module tb_button_press_decoder;
  localparam int SHORT = 1, LONG = 2, DOUBLE = 3;
  logic clk = 1'b0, reset = 1'b1, btn_level = 1'b0, enable = 1'b1;
  logic short_press, long_press, double_press, busy;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int kind; int cyc;} exp_t;
  exp_t q[$];
  button_press_decoder #(.LONG_TICKS(8), .GAP_TICKS(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .btn_level(btn_level), .enable(enable),
    .short_press(short_press), .long_press(long_press),
    .double_press(double_press), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      btn_level = b;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_at(input int kind, input int off);
    exp_t e;
    e.kind = kind;
    e.cyc = cyc + off;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    int kind;
    exp_t e;
    if (short_press || long_press || double_press) begin
      kind = short_press ? SHORT : long_press ? LONG : DOUBLE;
      chk("one_hot", int'(short_press) + int'(long_press) + int'(double_press), 1);
      if (q.size() == 0) chk("unexpected_pulse_kind", kind, 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    run(0, 3);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {short_press, long_press, double_press}, 0);
    run(0, 2);
    // short press
    run(1, 3);
    chk("short_busy_pressed", busy, 1);
    expect_at(SHORT, 4);
    run(0, 4);
    chk("short_busy_after", busy, 0);
    run(0, 2);
    // long press, then 7-sample hold resolving short
    expect_at(LONG, 8);
    run(1, 20);
    chk("long_busy_held", busy, 1);
    run(0, 3);
    chk("long_busy_after", busy, 0);
    run(1, 7);
    expect_at(SHORT, 4);
    run(0, 4);
    run(0, 2);
    // double press within gap
    run(1, 2);
    run(0, 3);
    expect_at(DOUBLE, 1);
    run(1, 2);
    chk("double_busy_second", busy, 1);
    run(0, 6);
    chk("double_busy_after", busy, 0);
    // gap expired: two separate short presses
    run(1, 2);
    expect_at(SHORT, 4);
    run(0, 4);
    run(1, 2);
    expect_at(SHORT, 4);
    run(0, 4);
    run(0, 2);
    // button held through reset
    btn_level = 1'b1;
    reset = 1'b1;
    run(1, 3);
    reset = 1'b0;
    run(1, 20);
    chk("held_reset_busy", busy, 0);
    run(0, 2);
    run(1, 2);
    expect_at(SHORT, 4);
    run(0, 4);
    run(0, 2);
    // enable gating on the deciding sample
    run(1, 7);
    enable = 1'b0;
    run(1, 1);
    chk("enable_busy_off", busy, 0);
    run(1, 3);
    enable = 1'b1;
    run(1, 5);
    chk("enable_held_ignored", busy, 0);
    run(0, 2);
    run(1, 2);
    expect_at(SHORT, 4);
    run(0, 4);
    run(0, 2);
    // reset mid-gap
    run(1, 2);
    run(0, 2);
    reset = 1'b1;
    run(0, 1);
    reset = 1'b0;
    chk("midgap_reset_busy", busy, 0);
    chk("midgap_reset_pulses", {short_press, long_press, double_press}, 0);
    run(0, 6);
    chk("midgap_busy_after", busy, 0);
    chk("pending_expectations", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
